data_mem_responder: RTL

//  Data-memory responder at the far end of the decoder's load/store controls (MemWrite, memSize, memUnsigned).

---
 rtl/data_mem_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte/half/word loads and stores with byte-lane enables.
// An access that crosses a 32-bit word boundary is split into two word accesses.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LD2  = 2'd1,
        ST2  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [31:0] mem [DEPTH];

    logic [IDX_W-1:0] req_idx;
    logic [1:0]       req_off;
    logic [3:0]       size_mask;
    logic [7:0]       lane_span;
    logic [63:0]      data_span;
    logic             split;
    logic             accept;
    logic             unused_addr;

    logic [IDX_W-1:0] hi_idx;
    logic [3:0]       hi_lanes;
    logic [31:0]      hi_data;
    logic [31:0]      lo_word;
    logic [1:0]       ld_off;
    logic [1:0]       ld_size;
    logic             ld_unsigned;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [3:0]       wr_lanes;
    logic [31:0]      wr_data;
    logic [31:0]      rd_word;
    logic [31:0]      ld_word;

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size,
                                           input logic uns);
        case (size)
            2'b00:   extend = {{24{d[7] & ~uns}}, d[7:0]};
            2'b01:   extend = {{16{d[15] & ~uns}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    assign req_idx     = req_addr[ADDR_WIDTH-1:2];
    assign req_off     = req_addr[1:0];
    assign unused_addr = ^req_addr[31:ADDR_WIDTH];

    always_comb begin
        case (req_size)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    // Bytes shifted past lane 3 spill into the upper nibble / upper word: that part belongs to word A+1.
    assign lane_span = {4'b0000, size_mask} << req_off;
    assign data_span = {32'd0, req_wdata} << {req_off, 3'b000};
    assign split     = |lane_span[7:4];
    assign accept    = req_valid & req_ready;
    assign busy      = (state != IDLE);

    // NOTE: every output of this block is given a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = req_idx;
        wr_lanes   = lane_span[3:0];
        wr_data    = data_span[31:0];
        rd_idx     = req_idx;
        case (state)
            IDLE: begin
                req_ready = ~rst;
                if (req_valid && !rst) begin
                    wr_en = req_we;
                    if (split) state_next = req_we ? ST2 : LD2;
                end
            end
            LD2: begin
                rd_idx     = hi_idx;
                state_next = IDLE;
            end
            ST2: begin
                wr_en      = ~rst;
                wr_idx     = hi_idx;
                wr_lanes   = hi_lanes;
                wr_data    = hi_data;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the array is deliberately not reset; its contents are undefined until written, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && wr_lanes[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    assign rd_word = mem[rd_idx];
    assign ld_word = 32'({rd_word, lo_word} >> {ld_off, 3'b000});

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_next;
            rsp_valid <= 1'b0;
            if (accept && !req_we && !split) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= extend(rd_word >> {req_off, 3'b000}, req_size, req_unsigned);
            end else if (state == LD2) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= extend(ld_word, ld_size, ld_unsigned);
            end
        end
    end

    // Context for the second half of a split access.
    always_ff @(posedge clk) begin
        if (accept && split) begin
            hi_idx      <= req_idx + IDX_W'(1);
            hi_lanes    <= lane_span[7:4];
            hi_data     <= data_span[63:32];
            lo_word     <= rd_word;
            ld_off      <= req_off;
            ld_size     <= req_size;
            ld_unsigned <= req_unsigned;
        end
    end

endmodule
